abus_arb: RTL and testbench
===========================

Name: abus_arb

Overview:
- Registered N-way bus arbiter; next generation of the combinational lower-first arbiter.
- Adds runtime-selectable fixed-priority or round-robin policy, grant hold across bursts, per-master lock, and a bounded hold length for fairness.
- Sits between the bus masters' request lines and the abus mux select; drives a one-hot grant plus an encoded owner index.

Parameters:
- N, 8, number of requesting masters (2..32).
- MAX_HOLD, 16, maximum consecutive cycles one owner keeps the grant while others request; 0 = unlimited.
- HW, $clog2(MAX_HOLD+1), hold counter width (derived, not overridden).
- IW, $clog2(N), owner index width (derived).

Ports:
- clk  in  1  bus clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  0 = fixed lower-first, 1 = round-robin; sampled at each arbitration.
- req  in  N  request per master, level, held until served.
- lock  in  N  lock per master; the owner's lock bit suppresses MAX_HOLD pre-emption.
- grant  out  N  registered one-hot grant, or all zero.
- grant_valid  out  1  OR of grant.
- grant_id  out  IW  index of the granted master; 0 when grant_valid = 0.

Behaviour:
- Reset (async assert, sync release by integrator): grant=0, grant_valid=0, grant_id=0, rr pointer=0, hold counter=0.
- Two states:
  - IDLE: no owner.
  - OWNED: one owner.
- IDLE -> OWNED at the edge after any req bit is seen. Latency is 1 cycle: req sampled at edge k gives grant at edge k+1.
- Arbitration (combinational, used in IDLE or when the owner is released):
  - mode 0: lowest set req index wins.
  - mode 1: first set req index at or above the pointer, wrapping past N-1 to 0.
- Owner release conditions, evaluated each cycle in OWNED:
  - a) req[owner]=0: re-arbitrate over the remaining req; the new grant appears at the next edge with no idle cycle. If none, go to IDLE and drive grant=0.
  - b) MAX_HOLD!=0, hold counter = MAX_HOLD-1, lock[owner]=0 and another req is set: re-arbitrate, excluding the owner for that decision only.
  - c) Otherwise the owner keeps the grant and the hold counter increments, saturating at MAX_HOLD-1.
- Expiry with no competing request: the owner keeps the grant and the hold counter restarts at 0.
- Hold counter clears to 0 on every change of owner and on entering IDLE.
- Round-robin pointer is loaded with (new owner + 1) mod N on every grant change in either mode, so switching mode to 1 starts fairly.
- A mode change mid-ownership does not pre-empt; it applies at the next arbitration.
- lock bits of non-owners are ignored. A lock with its req low has no effect (rule a has priority).
- grant is always one-hot or zero, and grant_id always matches grant.
- Reset asserted mid-ownership drops grant to 0 immediately, without waiting for a clock edge.

Decomposition:
- Package abus_pkg holds:
  - enum arb_mode_e {ARB_FIXED=0, ARB_RR=1}
  - enum arb_state_e {ARB_IDLE, ARB_OWNED}
  - constant ABUS_MAX_N=32
- Sub-module abus_pick: combinational find-first-set from a start index with wrap and an exclude mask. Output is a one-hot vector plus an index. It is instantiated once, with start index = 0 in fixed mode and = pointer in round-robin mode.

Test Plan:
- N=8, mode=0, sweep req 0..255, one value per cycle, with req dropped between values -> each grant is the lowest set bit one cycle later; req=0 gives grant=0 and grant_valid=0.
- N=4, mode=1, req=4'b1111 held, MAX_HOLD=1 -> grant_id sequence 0,1,2,3,0 on consecutive cycles, and the per-master counts are equal after 400 cycles.
- N=4, MAX_HOLD=4, mode=0, req=4'b0011 held -> grant_id=0 for 4 cycles, then 1 for 4 cycles, alternating. With lock[0]=1, grant_id stays 0 for 20 cycles.
- Owner 2 drops req while req[1]=1, mode=1 -> grant moves to 1 at the next edge with no zero-grant cycle; pointer=2.
- Single requester req=4'b1000, MAX_HOLD=2 -> grant stays 4'b1000 for 10 cycles and the hold counter wraps without a glitch.
- Assert rst mid-burst between clock edges -> grant=0 and grant_id=0 immediately. After release with req=4'b0110, mode=1 -> grant_id=1 (pointer restarted at 0).
- Every scenario: a negedge checker asserts $onehot0(grant) and that grant_id matches grant.

Source files
------------

// File: rtl/abus_pkg.sv
// Shared types and limits for the abus arbiter.
package abus_pkg;

    localparam int unsigned ABUS_MAX_N = 32;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/abus_pick.sv
// Find-first-set over req & ~excl, scanning upward from start and wrapping past N-1.
module abus_pick
    import abus_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  excl,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [N-1:0] cand;

    assign cand = req & ~excl;

    // Walk candidates in priority order from start; the first hit wins.
    always_comb begin
        int unsigned pos;
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = 32'(start) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found && cand[IW'(pos)]) begin
                found               = 1'b1;
                onehot[IW'(pos)]    = 1'b1;
                idx                 = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/abus_arb.sv
// Registered N-way abus arbiter: fixed or round-robin policy, burst hold, lock, bounded hold.
module abus_arb
    import abus_pkg::*;
#(
    parameter  int unsigned N        = 8,
    parameter  int unsigned MAX_HOLD = 16,
    localparam int unsigned HW       = $clog2(MAX_HOLD + 1),
    localparam int unsigned IW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  lock,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic [IW-1:0] grant_id
);

    // Counter needs at least one bit even when the hold is unlimited.
    localparam int unsigned CW = (HW < 1) ? 1 : HW;
    localparam logic [CW-1:0] HOLD_TOP = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    arb_state_e    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] id_q, id_d;
    logic          valid_q, valid_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] hold_q, hold_d;

    logic [N-1:0]  pick_onehot;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic [IW-1:0] pick_start;
    logic          owner_req;
    logic          owner_lock;
    logic          others;
    logic          expire;
    logic          take;

    assign owner_req  = |(req & grant_q);
    assign owner_lock = |(lock & grant_q);
    assign others     = |(req & ~grant_q);
    assign expire     = (MAX_HOLD != 0) && (hold_q == HOLD_TOP);
    assign pick_start = (arb_mode_e'(mode) == ARB_RR) ? ptr_q : '0;

    // The current owner is always excluded: on release its req is already low,
    // and on hold expiry it must not win its own re-arbitration.
    abus_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .excl   (grant_q),
        .start  (pick_start),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    // Next-state, grant, pointer and hold-counter decisions.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        take    = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    take = 1'b1;
                end
            end
            ARB_OWNED: begin
                if (!owner_req) begin
                    if (pick_found) begin
                        take = 1'b1;
                    end else begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                        id_d    = '0;
                        valid_d = 1'b0;
                        hold_d  = '0;
                    end
                end else if (expire && !owner_lock && others) begin
                    take = 1'b1;
                end else if (expire && !others) begin
                    hold_d = '0;
                end else if (hold_q != HOLD_TOP) begin
                    hold_d = hold_q + CW'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (take) begin
            state_d = ARB_OWNED;
            grant_d = pick_onehot;
            id_d    = pick_idx;
            valid_d = 1'b1;
            hold_d  = '0;
            ptr_d   = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + IW'(1);
        end
    end

    // State and output registers; reset clears grant without waiting for an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_id    = id_q;

endmodule

// File: tb/tb_abus_arb.sv
// Directed bench for abus_arb across four parameterisations.
module tb_abus_arb;

    logic clk;
    logic rst;

    logic [7:0] req8, lock8, grant8;
    logic       mode8, gv8;
    logic [2:0] gid8;

    logic [3:0] req_a, lock_a, grant_a;
    logic       mode_a, gv_a;
    logic [1:0] gid_a;

    logic [3:0] req_b, lock_b, grant_b;
    logic       mode_b, gv_b;
    logic [1:0] gid_b;

    logic [3:0] req_c, lock_c, grant_c;
    logic       mode_c, gv_c;
    logic [1:0] gid_c;

    int checks = 0;
    int errors = 0;

    abus_arb #(.N(8), .MAX_HOLD(16)) u8 (
        .clk(clk), .rst(rst), .mode(mode8), .req(req8), .lock(lock8),
        .grant(grant8), .grant_valid(gv8), .grant_id(gid8)
    );
    abus_arb #(.N(4), .MAX_HOLD(1)) u4a (
        .clk(clk), .rst(rst), .mode(mode_a), .req(req_a), .lock(lock_a),
        .grant(grant_a), .grant_valid(gv_a), .grant_id(gid_a)
    );
    abus_arb #(.N(4), .MAX_HOLD(4)) u4b (
        .clk(clk), .rst(rst), .mode(mode_b), .req(req_b), .lock(lock_b),
        .grant(grant_b), .grant_valid(gv_b), .grant_id(gid_b)
    );
    abus_arb #(.N(4), .MAX_HOLD(2)) u4c (
        .clk(clk), .rst(rst), .mode(mode_c), .req(req_c), .lock(lock_c),
        .grant(grant_c), .grant_valid(gv_c), .grant_id(gid_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] low_idx(input logic [31:0] g);
        for (int i = 0; i < 32; i++) begin
            if (g[i]) return 32'(i);
        end
        return 32'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Structural invariants on every instance, sampled mid-cycle.
    always @(negedge clk) begin
        chk("oh8",  32'($onehot0(grant8)),  32'd1);
        chk("id8",  32'(gid8),  low_idx(32'(grant8)));
        chk("v8",   32'(gv8),   32'(|grant8));
        chk("oha",  32'($onehot0(grant_a)), 32'd1);
        chk("ida",  32'(gid_a), low_idx(32'(grant_a)));
        chk("ohb",  32'($onehot0(grant_b)), 32'd1);
        chk("idb",  32'(gid_b), low_idx(32'(grant_b)));
        chk("ohc",  32'($onehot0(grant_c)), 32'd1);
        chk("idc",  32'(gid_c), low_idx(32'(grant_c)));
    end

    initial begin
        logic [7:0] vb;
        logic [7:0] lb;
        int cnt [4];

        rst = 1'b1;
        req8 = '0; lock8 = '0; mode8 = 1'b0;
        req_a = '0; lock_a = '0; mode_a = 1'b0;
        req_b = '0; lock_b = '0; mode_b = 1'b0;
        req_c = '0; lock_c = '0; mode_c = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant8", 32'(grant8), 32'd0);
        chk("rst_gv8",    32'(gv8),    32'd0);
        chk("rst_gid8",   32'(gid8),   32'd0);
        chk("rst_ptr8",   32'(u8.ptr_q),  32'd0);
        chk("rst_hold8",  32'(u8.hold_q), 32'd0);
        chk("rst_grantc", 32'(grant_c), 32'd0);
        rst = 1'b0;

        // Fixed priority sweep with req dropped between values.
        for (int v = 0; v < 256; v++) begin
            vb = 8'(v);
            lb = vb & (~vb + 8'd1);
            req8 = vb;
            step();
            chk("sweep_grant", 32'(grant8), 32'(lb));
            chk("sweep_gv",    32'(gv8),    32'(v != 0));
            chk("sweep_gid",   32'(gid8),   low_idx(32'(lb)));
            req8 = '0;
            step();
            chk("sweep_drop",  32'(grant8), 32'd0);
            chk("sweep_dropv", 32'(gv8),    32'd0);
        end

        // Round robin with MAX_HOLD=1: strict rotation and equal share.
        mode_a = 1'b1;
        req_a  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_seq", 32'(gid_a), 32'(k % 4));
        end
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int k = 0; k < 400; k++) begin
            step();
            cnt[gid_a] = cnt[gid_a] + 1;
        end
        for (int i = 0; i < 4; i++) begin
            chk("rr_share", 32'(cnt[i]), 32'd100);
        end
        req_a = '0;

        // Bounded hold in fixed mode, then lock suppressing pre-emption.
        req_b = 4'b0011;
        for (int k = 0; k < 16; k++) begin
            step();
            chk("hold_alt", 32'(gid_b), 32'((k / 4) % 2));
        end
        lock_b = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("lock_keep", 32'(gid_b), 32'd0);
        end
        chk("lock_sat", 32'(u4b.hold_q), 32'd3);
        lock_b = '0;
        step();
        chk("unlock_move", 32'(gid_b), 32'd1);
        req_b = '0;

        // Single requester: grant steady while the hold counter wraps.
        req_c = 4'b1000;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("single_grant", 32'(grant_c), 32'h8);
            chk("single_hold",  32'(u4c.hold_q), 32'(k % 2));
        end

        // Owner release hands over at the next edge with no idle cycle.
        mode_c = 1'b1;
        req_c  = 4'b0100;
        step();
        chk("rel_to2",   32'(grant_c), 32'h4);
        chk("rel_ptr3",  32'(u4c.ptr_q), 32'd3);
        req_c = 4'b0010;
        step();
        chk("rel_to1",   32'(grant_c), 32'h2);
        chk("rel_gv",    32'(gv_c),    32'd1);
        chk("rel_ptr2",  32'(u4c.ptr_q), 32'd2);

        // Asynchronous reset between edges.
        req_c = 4'b0110;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_grant", 32'(grant_c), 32'd0);
        chk("arst_gid",   32'(gid_c),   32'd0);
        chk("arst_gv",    32'(gv_c),    32'd0);
        chk("arst_ptr",   32'(u4c.ptr_q), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("post_rst_gid", 32'(gid_c), 32'd1);
        chk("post_rst_gv",  32'(gv_c),  32'd1);
        req_c = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
